replacement_ctrl: RTL and testbench
===================================

# replacement_ctrl

Sequencer for the cache replacement-policy state memory. Owns the policy's `write_en`, `way_hit` and `line_addr` inputs and shares them between three users: hit updates, miss victim allocation with line fill, and a full-memory invalidate sweep. It sits between the cache front-end and the `replacement_policy` instance. It also keeps saturating hit and miss counters for performance monitoring.

## Interface
Parameters:
- `N_WAYS`, 4: associativity, a power of two and at least 2.
- `LINE_OFF_W`, 7: line-index width. The sweep covers 2^LINE_OFF_W entries.
- `NWAY_W`, $clog2(N_WAYS): width of the binary way index.
- `CNT_W`, 16: width of each performance counter.

Ports:
- `clk`  in  1: clock.
- `reset`  in  1: asynchronous, active-low reset.
- `access_valid`  in  1: front-end lookup is valid this cycle.
- `access_ready`  out  1: controller accepts the lookup.
- `access_line_addr`  in  LINE_OFF_W: line index of the lookup.
- `access_way_hit`  in  N_WAYS: one-hot tag-compare result. All zeros means a miss.
- `invalidate`  in  1: request to reinitialise every policy entry.
- `invalidate_done`  out  1: one-cycle pulse when the sweep finishes.
- `fill_req`  out  1: a line fill is outstanding into `victim_way`.
- `fill_done`  in  1: the fill has completed.
- `victim_way`  out  N_WAYS: one-hot victim way, held stable while `fill_req` is high.
- `victim_way_bin`  out  NWAY_W: binary form of `victim_way`.
- `rp_way_select`  in  N_WAYS: victim way from the policy, combinational on `rp_line_addr`.
- `rp_write_en`  out  1: write enable for the policy memory.
- `rp_way_hit`  out  N_WAYS: way-hit vector driven to the policy.
- `rp_line_addr`  out  LINE_OFF_W: policy memory address.
- `rp_init`  out  1: datapath forces the policy write data to its reset value.
- `cnt_clr`  in  1: synchronous clear of both counters.
- `hit_cnt`  out  CNT_W: saturating count of hits.
- `miss_cnt`  out  CNT_W: saturating count of misses.

## Operation
The controller has four states: IDLE, FILL, UPDATE and SWEEP. A pending-invalidate flag `inv_pend` is set by `invalidate` in any state other than SWEEP. The flag is cleared when SWEEP is entered.

`access_ready` = (state==IDLE) & ~inv_pend & ~invalidate.

`rp_line_addr` mux:
- IDLE: `access_line_addr`.
- FILL or UPDATE: the latched line index.
- SWEEP: the sweep counter.

IDLE:
- If `invalidate | inv_pend`, go to SWEEP. Invalidate takes priority over a simultaneous access, and that access is not accepted.
- Accepted hit (`access_way_hit`≠0):
  - `rp_write_en`=1 and `rp_way_hit`=`access_way_hit` in the same cycle.
  - `hit_cnt` increments.
  - State stays IDLE, so back-to-back hits are accepted every cycle.
- Accepted miss:
  - Latch `access_line_addr`.
  - Latch `rp_way_select` as the victim. If `rp_way_select` is all zeros, way 0 is used.
  - `miss_cnt` increments.
  - No policy write. Go to FILL.

FILL:
- `fill_req`=1 and `rp_write_en`=0.
- On `fill_done`, go to UPDATE.
- `fill_done` outside FILL is ignored.

UPDATE:
- `rp_write_en`=1 with `rp_way_hit`=victim, at the latched index.
- Go to IDLE. Invalidate is serviced next if it is pending.

SWEEP:
- Counter starts at 0.
- Every cycle: `rp_write_en`=1, `rp_init`=1, `rp_way_hit`=0, then the counter increments.
- On index 2^LINE_OFF_W−1, `invalidate_done` pulses in that same cycle, and the next state is IDLE.
- `invalidate` asserted during SWEEP is ignored.

Counters:
- Both counters saturate at all-ones.
- `cnt_clr` has priority over an increment in the same cycle.

`victim_way` and `victim_way_bin` hold their last latched value outside FILL and UPDATE.

## Timing
- Reset values: state IDLE, `access_ready`=1, `inv_pend`=0, counters 0, victim 0. All other outputs 0.
- Reset asserted mid-operation aborts FILL or SWEEP immediately with no completion pulse.
- Hit update latency is 0 cycles: the write occurs in the acceptance cycle.
- Miss sequence: accepted at cycle T, `fill_req` high from T+1. If `fill_done` arrives at cycle F, the policy write happens at F+1 and `access_ready` returns at F+2. The minimum is `access_ready` at T+3.
- Sweep: entered at cycle S, writes occupy S+1 … S+2^LINE_OFF_W, and `access_ready` returns the following cycle.
- `fill_req`, `victim_way`, `victim_way_bin`, `rp_init` and `invalidate_done` are decoded from registered state only. They are glitch-free with respect to inputs.

## Test plan
- Reset, then hits on ways 1, 2, 3 at index 5 on consecutive cycles → three writes at addr 5 with `rp_way_hit`=0010/0100/1000, `access_ready` stays 1, `hit_cnt`=3.
- Miss at index 9 with `rp_way_select`=0100, then `fill_done` 4 cycles later → `victim_way_bin`=2 held throughout, single write of way_hit 0100 at addr 9 one cycle after `fill_done`, `miss_cnt`=1.
- `invalidate` together with a hit in IDLE → hit not accepted, 128 writes to addresses 0..127 with `rp_init`=1, `invalidate_done` pulses once at address 127.
- `invalidate` pulsed during FILL → fill completes and UPDATE is written, then the sweep starts immediately without reasserting `invalidate`.
- With CNT_W=2, apply 5 hits and assert `cnt_clr` together with a 6th hit → `hit_cnt` reads 3 then 0.
- Drop reset mid-sweep at address 40 → all outputs return to reset values asynchronously, and there is no `invalidate_done`.

Source files
------------

// File: rtl/replacement_ctrl.sv
// replacement_ctrl
// Sequences access to the replacement-policy state memory between three users:
// hit updates (same-cycle write), miss victim allocation with a line fill, and
// a full-memory invalidate sweep. Also keeps saturating hit/miss counters.
//
// Ports:
//   clk, reset (async, active low)
//   access_valid/ready, access_line_addr, access_way_hit : front-end lookup
//   invalidate, invalidate_done                           : sweep request/finish
//   fill_req, fill_done, victim_way, victim_way_bin        : line fill handshake
//   rp_way_select, rp_write_en, rp_way_hit, rp_line_addr,
//   rp_init                                                : policy memory side
//   cnt_clr, hit_cnt, miss_cnt                             : perf counters
module replacement_ctrl #(
    parameter int N_WAYS     = 4,
    parameter int LINE_OFF_W = 7,
    parameter int NWAY_W     = $clog2(N_WAYS),
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  access_valid,
    output logic                  access_ready,
    input  logic [LINE_OFF_W-1:0] access_line_addr,
    input  logic [N_WAYS-1:0]     access_way_hit,
    input  logic                  invalidate,
    output logic                  invalidate_done,
    output logic                  fill_req,
    input  logic                  fill_done,
    output logic [N_WAYS-1:0]     victim_way,
    output logic [NWAY_W-1:0]     victim_way_bin,
    input  logic [N_WAYS-1:0]     rp_way_select,
    output logic                  rp_write_en,
    output logic [N_WAYS-1:0]     rp_way_hit,
    output logic [LINE_OFF_W-1:0] rp_line_addr,
    output logic                  rp_init,
    input  logic                  cnt_clr,
    output logic [CNT_W-1:0]      hit_cnt,
    output logic [CNT_W-1:0]      miss_cnt
);

    typedef enum logic [1:0] {IDLE, FILL, UPDATE, SWEEP} state_e;

    state_e                  state_q, state_d;
    logic                    inv_pend_q, inv_pend_d;
    logic [LINE_OFF_W-1:0]   line_q, line_d;
    logic [N_WAYS-1:0]       victim_q, victim_d;
    logic [LINE_OFF_W-1:0]   sweep_q, sweep_d;
    logic [CNT_W-1:0]        hit_q, hit_d, miss_q, miss_d;

    logic acc_hit, acc_miss, sweep_last;

    assign access_ready = (state_q == IDLE) && !inv_pend_q && !invalidate;
    assign acc_hit      = access_valid && access_ready && (|access_way_hit);
    assign acc_miss     = access_valid && access_ready && !(|access_way_hit);
    assign sweep_last   = (state_q == SWEEP) && (&sweep_q);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:   if (invalidate || inv_pend_q) state_d = SWEEP;
                    else if (acc_miss)            state_d = FILL;
            FILL:   if (fill_done)                state_d = UPDATE;
            UPDATE:                               state_d = IDLE;
            SWEEP:  if (sweep_last)               state_d = IDLE;
            default:                              state_d = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        rp_write_en     = 1'b0;
        rp_way_hit      = '0;
        rp_line_addr    = access_line_addr;
        rp_init         = 1'b0;
        fill_req        = 1'b0;
        invalidate_done = 1'b0;
        unique case (state_q)
            IDLE: begin
                rp_write_en = acc_hit;
                rp_way_hit  = acc_hit ? access_way_hit : '0;
            end
            FILL: begin
                fill_req     = 1'b1;
                rp_line_addr = line_q;
            end
            UPDATE: begin
                rp_write_en  = 1'b1;
                rp_way_hit   = victim_q;
                rp_line_addr = line_q;
            end
            SWEEP: begin
                rp_write_en     = 1'b1;
                rp_init         = 1'b1;
                rp_line_addr    = sweep_q;
                invalidate_done = sweep_last;
            end
            default: ;
        endcase
    end

    // Datapath next-state
    always_comb begin
        line_d   = line_q;
        victim_d = victim_q;
        if (acc_miss) begin
            line_d   = access_line_addr;
            // An empty policy answer still needs a valid victim: fall back to way 0.
            victim_d = (|rp_way_select) ? rp_way_select : N_WAYS'(1);
        end
        // Counter is held at 0 outside SWEEP so each sweep starts from entry 0.
        sweep_d = (state_q == SWEEP) ? sweep_q + 1'b1 : '0;

        // Pending flag clears on the IDLE->SWEEP transition, which also covers
        // an invalidate arriving in that same cycle.
        inv_pend_d = inv_pend_q;
        if (state_q == IDLE && state_d == SWEEP)   inv_pend_d = 1'b0;
        else if (invalidate && state_q != SWEEP)   inv_pend_d = 1'b1;

        hit_d  = hit_q;
        miss_d = miss_q;
        if (cnt_clr) begin
            hit_d  = '0;
            miss_d = '0;
        end else begin
            if (acc_hit  && !(&hit_q))  hit_d  = hit_q + 1'b1;
            if (acc_miss && !(&miss_q)) miss_d = miss_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inv_pend_q <= 1'b0;
            line_q     <= '0;
            victim_q   <= '0;
            sweep_q    <= '0;
            hit_q      <= '0;
            miss_q     <= '0;
        end else begin
            inv_pend_q <= inv_pend_d;
            line_q     <= line_d;
            victim_q   <= victim_d;
            sweep_q    <= sweep_d;
            hit_q      <= hit_d;
            miss_q     <= miss_d;
        end
    end

    // One-hot to binary for the registered victim
    always_comb begin
        victim_way_bin = '0;
        for (int i = 0; i < N_WAYS; i++)
            if (victim_q[i]) victim_way_bin = victim_way_bin | NWAY_W'(i);
    end

    assign victim_way = victim_q;
    assign hit_cnt    = hit_q;
    assign miss_cnt   = miss_q;

endmodule

// File: tb/tb_replacement_ctrl.sv
module tb_replacement_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       access_valid;
    logic [6:0] access_line_addr;
    logic [3:0] access_way_hit;
    logic       invalidate;
    logic       fill_done;
    logic [3:0] rp_way_select;
    logic       cnt_clr;

    logic        access_ready, invalidate_done, fill_req, rp_write_en, rp_init;
    logic [3:0]  victim_way, rp_way_hit;
    logic [1:0]  victim_way_bin;
    logic [6:0]  rp_line_addr;
    logic [15:0] hit_cnt, miss_cnt;

    // Second instance with 2-bit counters for saturation checks
    logic        s_ready, s_done, s_freq, s_we, s_init;
    logic [3:0]  s_vw, s_rwh;
    logic [1:0]  s_vb;
    logic [6:0]  s_ra;
    logic [1:0]  s_hit, s_miss;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    replacement_ctrl dut (
        .clk(clk), .reset(reset), .access_valid(access_valid), .access_ready(access_ready),
        .access_line_addr(access_line_addr), .access_way_hit(access_way_hit),
        .invalidate(invalidate), .invalidate_done(invalidate_done), .fill_req(fill_req),
        .fill_done(fill_done), .victim_way(victim_way), .victim_way_bin(victim_way_bin),
        .rp_way_select(rp_way_select), .rp_write_en(rp_write_en), .rp_way_hit(rp_way_hit),
        .rp_line_addr(rp_line_addr), .rp_init(rp_init), .cnt_clr(cnt_clr),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    replacement_ctrl #(.CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .access_valid(access_valid), .access_ready(s_ready),
        .access_line_addr(access_line_addr), .access_way_hit(access_way_hit),
        .invalidate(invalidate), .invalidate_done(s_done), .fill_req(s_freq),
        .fill_done(fill_done), .victim_way(s_vw), .victim_way_bin(s_vb),
        .rp_way_select(rp_way_select), .rp_write_en(s_we), .rp_way_hit(s_rwh),
        .rp_line_addr(s_ra), .rp_init(s_init), .cnt_clr(cnt_clr),
        .hit_cnt(s_hit), .miss_cnt(s_miss)
    );

    typedef struct {
        logic       v;  logic [6:0] a;  logic [3:0] wh; logic fd; logic [3:0] sel;
        logic       rdy; logic we; logic [3:0] rwh; logic [6:0] ra;
        logic       fr; logic [3:0] vw; logic [1:0] vb;
    } vec_t;

    vec_t tbl[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        access_valid = 0; access_line_addr = '0; access_way_hit = '0;
        invalidate = 0; fill_done = 0; rp_way_select = '0; cnt_clr = 0;
    endtask

    // Drive at the falling edge, sample 1ns later (well before the rising edge).
    task automatic drive_hit(input logic [6:0] a, input logic [3:0] wh, input logic clr);
        @(negedge clk);
        idle_inputs();
        access_valid = 1; access_line_addr = a; access_way_hit = wh; cnt_clr = clr;
        #1;
    endtask

    initial begin
        int seen;
        idle_inputs();
        reset = 0;

        //          v  a  wh   fd sel   rdy we rwh  ra fr vw   vb
        tbl[0]  = '{0, 0, 4'h0, 0, 4'h0, 1, 0, 4'h0, 0, 0, 4'h0, 0};
        tbl[1]  = '{1, 5, 4'h2, 0, 4'h0, 1, 1, 4'h2, 5, 0, 4'h0, 0};
        tbl[2]  = '{1, 5, 4'h4, 0, 4'h0, 1, 1, 4'h4, 5, 0, 4'h0, 0};
        tbl[3]  = '{1, 5, 4'h8, 0, 4'h0, 1, 1, 4'h8, 5, 0, 4'h0, 0};
        tbl[4]  = '{1, 9, 4'h0, 0, 4'h4, 1, 0, 4'h0, 9, 0, 4'h0, 0};
        tbl[5]  = '{0, 0, 4'h0, 0, 4'h1, 0, 0, 4'h0, 9, 1, 4'h4, 2};
        tbl[6]  = '{0, 0, 4'h0, 0, 4'h1, 0, 0, 4'h0, 9, 1, 4'h4, 2};
        tbl[7]  = '{0, 0, 4'h0, 0, 4'h1, 0, 0, 4'h0, 9, 1, 4'h4, 2};
        tbl[8]  = '{0, 0, 4'h0, 1, 4'h1, 0, 0, 4'h0, 9, 1, 4'h4, 2};
        tbl[9]  = '{1, 3, 4'h1, 0, 4'h0, 0, 1, 4'h4, 9, 0, 4'h4, 2};
        tbl[10] = '{0, 0, 4'h0, 0, 4'h0, 1, 0, 4'h0, 0, 0, 4'h4, 2};
        tbl[11] = '{1, 7, 4'h0, 0, 4'h0, 1, 0, 4'h0, 7, 0, 4'h4, 2};
        tbl[12] = '{0, 0, 4'h0, 1, 4'h0, 0, 0, 4'h0, 7, 1, 4'h1, 0};
        tbl[13] = '{0, 0, 4'h0, 0, 4'h0, 0, 1, 4'h1, 7, 0, 4'h1, 0};
        tbl[14] = '{0, 0, 4'h0, 1, 4'h0, 1, 0, 4'h0, 0, 0, 4'h1, 0};
        tbl[15] = '{0, 0, 4'h0, 0, 4'h0, 1, 0, 4'h0, 0, 0, 4'h1, 0};

        repeat (2) @(negedge clk);
        #1;
        chk("rst_ready", access_ready, 1);
        chk("rst_we", rp_write_en, 0);
        chk("rst_victim", victim_way, 0);
        chk("rst_hitcnt", hit_cnt, 0);
        chk("rst_misscnt", miss_cnt, 0);
        chk("rst_fillreq", fill_req, 0);
        @(negedge clk);
        reset = 1;

        // Hits, then a miss with a 4-cycle fill, then a miss with empty select
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            idle_inputs();
            access_valid = tbl[i].v; access_line_addr = tbl[i].a; access_way_hit = tbl[i].wh;
            fill_done = tbl[i].fd; rp_way_select = tbl[i].sel;
            #1;
            chk($sformatf("v%0d_ready", i), access_ready, tbl[i].rdy);
            chk($sformatf("v%0d_we", i), rp_write_en, tbl[i].we);
            chk($sformatf("v%0d_rwh", i), rp_way_hit, tbl[i].rwh);
            chk($sformatf("v%0d_addr", i), rp_line_addr, tbl[i].ra);
            chk($sformatf("v%0d_init", i), rp_init, 0);
            chk($sformatf("v%0d_fillreq", i), fill_req, tbl[i].fr);
            chk($sformatf("v%0d_victim", i), victim_way, tbl[i].vw);
            chk($sformatf("v%0d_vbin", i), victim_way_bin, tbl[i].vb);
        end
        chk("hit_cnt_3", hit_cnt, 3);
        chk("miss_cnt_2", miss_cnt, 2);
        chk("sat_hit_3", s_hit, 3);

        // Counter clear, saturation at CNT_W=2, clear beats increment
        @(negedge clk); idle_inputs(); cnt_clr = 1; #1;
        @(negedge clk); idle_inputs(); #1;
        chk("clr_hit", hit_cnt, 0);
        chk("clr_miss", miss_cnt, 0);
        for (int i = 0; i < 5; i++) drive_hit(7'd2, 4'h1, 0);
        @(negedge clk); idle_inputs(); #1;
        chk("hit_cnt_5", hit_cnt, 5);
        chk("sat_hit_5", s_hit, 3);
        drive_hit(7'd2, 4'h1, 1);
        chk("clr_hit_we", rp_write_en, 1);
        @(negedge clk); idle_inputs(); #1;
        chk("sat_clr_prio", s_hit, 0);
        chk("clr_prio", hit_cnt, 0);

        // Invalidate with a simultaneous hit: hit refused, full sweep
        @(negedge clk); idle_inputs();
        invalidate = 1; access_valid = 1; access_way_hit = 4'h2; access_line_addr = 7'd5;
        #1;
        chk("inv_ready", access_ready, 0);
        chk("inv_we", rp_write_en, 0);
        seen = 0;
        for (int i = 0; i < 128; i++) begin
            @(negedge clk); idle_inputs(); #1;
            chk($sformatf("sw%0d_we", i), rp_write_en, 1);
            chk($sformatf("sw%0d_init", i), rp_init, 1);
            chk($sformatf("sw%0d_rwh", i), rp_way_hit, 0);
            chk($sformatf("sw%0d_addr", i), rp_line_addr, i);
            chk($sformatf("sw%0d_done", i), invalidate_done, (i == 127));
            chk($sformatf("sw%0d_ready", i), access_ready, 0);
            if (invalidate_done) seen++;
        end
        @(negedge clk); idle_inputs(); #1;
        chk("sw_end_ready", access_ready, 1);
        chk("sw_end_done", invalidate_done, 0);
        chk("sw_done_once", seen, 1);
        chk("sw_hit_not_counted", hit_cnt, 0);

        // Invalidate during FILL: update completes, then sweep without re-request
        @(negedge clk); idle_inputs();
        access_valid = 1; access_line_addr = 7'd11; rp_way_select = 4'h8; #1;
        @(negedge clk); idle_inputs(); invalidate = 1; #1;
        chk("if_fillreq", fill_req, 1);
        @(negedge clk); idle_inputs(); #1;
        chk("if_fill_hold", fill_req, 1);
        @(negedge clk); idle_inputs(); fill_done = 1; #1;
        @(negedge clk); idle_inputs(); #1;
        chk("if_upd_we", rp_write_en, 1);
        chk("if_upd_rwh", rp_way_hit, 4'h8);
        chk("if_upd_addr", rp_line_addr, 11);
        chk("if_upd_init", rp_init, 0);
        @(negedge clk); idle_inputs(); access_valid = 1; access_way_hit = 4'h1; #1;
        chk("if_idle_ready", access_ready, 0);
        chk("if_idle_we", rp_write_en, 0);
        @(negedge clk); idle_inputs(); #1;
        chk("if_sweep_init", rp_init, 1);
        chk("if_sweep_addr", rp_line_addr, 0);
        seen = 0;
        for (int i = 0; i < 200 && seen == 0; i++) begin
            @(negedge clk); idle_inputs(); #1;
            if (invalidate_done) seen = 1;
        end
        chk("if_sweep_finish", seen, 1);

        // Reset dropped mid-sweep at address 40
        @(negedge clk); idle_inputs(); invalidate = 1; #1;
        seen = 0;
        for (int i = 0; i < 100 && seen == 0; i++) begin
            @(negedge clk); idle_inputs(); #1;
            if (rp_init && rp_line_addr == 7'd40) seen = 1;
        end
        chk("rs_reach40", seen, 1);
        reset = 0;
        #1;
        chk("rs_ready", access_ready, 1);
        chk("rs_we", rp_write_en, 0);
        chk("rs_init", rp_init, 0);
        chk("rs_addr", rp_line_addr, 0);
        chk("rs_fillreq", fill_req, 0);
        chk("rs_victim", victim_way, 0);
        chk("rs_vbin", victim_way_bin, 0);
        chk("rs_done", invalidate_done, 0);
        chk("rs_miss", miss_cnt, 0);
        seen = 0;
        repeat (3) begin
            @(negedge clk); #1;
            if (invalidate_done) seen++;
        end
        reset = 1;
        repeat (3) begin
            @(negedge clk); #1;
            if (invalidate_done || rp_write_en) seen++;
        end
        chk("rs_no_done", seen, 0);
        chk("rs_ready_after", access_ready, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
